// File: rtl/hazard3_muldiv_issue_pkg.sv
// Shared M-extension op encodings, issue FSM states and fusion helpers for the
// X-stage multiply/divide initiator.
package hazard3_muldiv_issue_pkg;

  localparam int W_MULOP = 3;

  localparam logic [W_MULOP-1:0] M_OP_MUL    = 3'd0;
  localparam logic [W_MULOP-1:0] M_OP_MULH   = 3'd1;
  localparam logic [W_MULOP-1:0] M_OP_MULHSU = 3'd2;
  localparam logic [W_MULOP-1:0] M_OP_MULHU  = 3'd3;
  localparam logic [W_MULOP-1:0] M_OP_DIV    = 3'd4;
  localparam logic [W_MULOP-1:0] M_OP_DIVU   = 3'd5;
  localparam logic [W_MULOP-1:0] M_OP_REM    = 3'd6;
  localparam logic [W_MULOP-1:0] M_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } issue_state_t;

  // Ops whose result lives in the low half of the responder accumulator.
  function automatic logic op_sel_low(input logic [W_MULOP-1:0] op);
    return (op == M_OP_MUL) || (op == M_OP_DIV) || (op == M_OP_DIVU);
  endfunction

  // Low product bits do not depend on signedness, so any MULH* leaves a valid MUL
  // result behind; a divide leaves both quotient and remainder of one signedness.
  function automatic logic fuse_pair(input logic [W_MULOP-1:0] last_op,
                                     input logic [W_MULOP-1:0] next_op);
    logic mulh_mul;
    logic sdiv;
    logic udiv;
    mulh_mul = ((last_op == M_OP_MULH) || (last_op == M_OP_MULHSU) || (last_op == M_OP_MULHU))
               && (next_op == M_OP_MUL);
    sdiv     = ((last_op == M_OP_DIV) || (last_op == M_OP_REM))
               && ((next_op == M_OP_DIV) || (next_op == M_OP_REM));
    udiv     = ((last_op == M_OP_DIVU) || (last_op == M_OP_REMU))
               && ((next_op == M_OP_DIVU) || (next_op == M_OP_REMU));
    return mulh_mul || sdiv || udiv;
  endfunction

endpackage

// File: rtl/hazard3_muldiv_fuse_match.sv
// Holds the operand/op tags of the last issued muldiv op and flags when the
// current X-stage op can be completed from the responder's held accumulator.
module hazard3_muldiv_fuse_match
  import hazard3_muldiv_issue_pkg::*;
#(
  parameter int W_DATA  = 32,
  parameter int W_MULOP = hazard3_muldiv_issue_pkg::W_MULOP,
  parameter int FUSE_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               latch,
  input  logic               arm,
  input  logic               clr,
  input  logic [W_MULOP-1:0] op,
  input  logic [W_DATA-1:0]  a,
  input  logic [W_DATA-1:0]  b,
  output logic               hit
);

  logic [W_DATA-1:0]  tag_a;
  logic [W_DATA-1:0]  tag_b;
  logic [W_MULOP-1:0] tag_op;
  logic               fuse_vld;

  // A new issue invalidates the accumulator until its result has landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_a    <= '0;
      tag_b    <= '0;
      tag_op   <= '0;
      fuse_vld <= 1'b0;
    end else if (latch) begin
      tag_a    <= a;
      tag_b    <= b;
      tag_op   <= op;
      fuse_vld <= 1'b0;
    end else if (clr) begin
      fuse_vld <= 1'b0;
    end else if (arm) begin
      fuse_vld <= (FUSE_EN != 0);
    end
  end

  // Operand values, not register indices, are compared so an rd==rs overwrite misses.
  assign hit = (FUSE_EN != 0) && fuse_vld && (a == tag_a) && (b == tag_b)
               && fuse_pair(tag_op, op);

endmodule

// File: rtl/hazard3_muldiv_issue.sv
// X-stage initiator for the sequential muldiv unit: issues M ops, stalls X until
// the result is ready, kills on flush and fuses back-to-back same-operand pairs.
//
//   state | meaning
//   IDLE  | no op in flight; issue or fuse the X-stage op
//   BUSY  | op accepted by the responder, waiting for mul_result_vld
//   DONE  | result held in the responder, x_result valid until consumed
module hazard3_muldiv_issue
  import hazard3_muldiv_issue_pkg::*;
#(
  parameter int W_DATA  = 32,
  parameter int W_MULOP = hazard3_muldiv_issue_pkg::W_MULOP,
  parameter int FUSE_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_vld,
  input  logic [W_MULOP-1:0] x_op,
  input  logic [W_DATA-1:0]  x_rs1,
  input  logic [W_DATA-1:0]  x_rs2,
  input  logic               x_flush,
  input  logic               x_advance,
  output logic               x_stall,
  output logic [W_DATA-1:0]  x_result,
  output logic               x_result_vld,
  output logic [W_MULOP-1:0] mul_op,
  output logic               mul_op_vld,
  input  logic               mul_op_rdy,
  output logic               mul_op_kill,
  output logic [W_DATA-1:0]  mul_op_a,
  output logic [W_DATA-1:0]  mul_op_b,
  input  logic [W_DATA-1:0]  mul_result_h,
  input  logic [W_DATA-1:0]  mul_result_l,
  input  logic               mul_result_vld
);

  issue_state_t       state;
  issue_state_t       state_nxt;
  logic [W_MULOP-1:0] op_r;
  logic               op_ld;
  logic               fuse_hit;
  logic               fuse_latch;
  logic               fuse_arm;
  logic               fuse_clr;

  assign mul_op   = x_op;
  assign mul_op_a = x_rs1;
  assign mul_op_b = x_rs2;

  hazard3_muldiv_fuse_match #(
    .W_DATA  (W_DATA),
    .W_MULOP (W_MULOP),
    .FUSE_EN (FUSE_EN)
  ) u_fuse_match (
    .clk   (clk),
    .rst_n (rst_n),
    .latch (fuse_latch),
    .arm   (fuse_arm),
    .clr   (fuse_clr),
    .op    (x_op),
    .a     (x_rs1),
    .b     (x_rs2),
    .hit   (fuse_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_r  <= '0;
    end else begin
      state <= state_nxt;
      if (op_ld) op_r <= x_op;
    end
  end

  always_comb begin
    state_nxt   = state;
    mul_op_vld  = 1'b0;
    mul_op_kill = 1'b0;
    fuse_latch  = 1'b0;
    fuse_arm    = 1'b0;
    fuse_clr    = 1'b0;
    op_ld       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (x_vld && !x_flush) begin
          if (fuse_hit) begin
            op_ld     = 1'b1;
            state_nxt = ST_DONE;
          end else if (mul_op_rdy) begin
            mul_op_vld = 1'b1;
            op_ld      = 1'b1;
            fuse_latch = 1'b1;
            state_nxt  = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (x_flush) begin
          mul_op_kill = 1'b1;
          fuse_clr    = 1'b1;
          state_nxt   = ST_IDLE;
        end else if (mul_result_vld) begin
          fuse_arm  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // A flush here only discards the result; the accumulator stays reusable.
        if (x_advance || x_flush) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The fused-hit cycle also stalls: its result only becomes visible in DONE.
  assign x_stall      = x_vld && !x_flush && (state != ST_DONE);
  assign x_result_vld = (state == ST_DONE);
  assign x_result     = op_sel_low(op_r) ? mul_result_l : mul_result_h;

endmodule

// File: tb/tb_hazard3_muldiv_issue.sv
// Scoreboard bench for hazard3_muldiv_issue: one fused and one non-fused instance,
// each paired with a behavioural sequential muldiv responder.
module tb_hazard3_muldiv_issue;

  localparam int LAT = 8;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        x_vld = 1'b0;
  logic [2:0]  x_op = '0;
  logic [31:0] x_rs1 = '0;
  logic [31:0] x_rs2 = '0;
  logic        x_flush = 1'b0;
  logic        x_advance = 1'b0;

  logic [1:0]       stall_v, rvld_v, op_vld_v, kill_v, rdy_v;
  logic [1:0][31:0] result_v, a_v, b_v;
  logic [1:0][2:0]  op_v;

  logic        x_stall, x_result_vld, mul_op_vld, mul_op_kill, mul_op_rdy;
  logic [31:0] x_result;

  int n_vec = 0;
  int n_err = 0;
  int n_issue = 0;
  int n_kill = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] res;
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    q = '0;
    r = '0;
    case (op)
      OP_MUL, OP_MULH: res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      OP_MULHSU:       res = {{32{a[31]}}, a} * {32'd0, b};
      OP_MULHU:        res = {32'd0, a} * {32'd0, b};
      OP_DIV, OP_REM: begin
        if (b == 32'd0) begin q = '1; r = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = '0; end
        else begin q = 32'(sa / sb); r = 32'(sa % sb); end
        res = {r, q};
      end
      default: begin
        if (b == 32'd0) begin q = '1; r = a; end
        else begin q = a / b; r = a % b; end
        res = {r, q};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] expect_of(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] full;
    full = ref_calc(op, a, b);
    return (op == OP_MUL || op == OP_DIV || op == OP_DIVU) ? full[31:0] : full[63:32];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        busy, rvld;
    logic [3:0]  cnt;
    logic [2:0]  pop;
    logic [31:0] pa, pb, rh, rl;

    hazard3_muldiv_issue #(.W_DATA(32), .W_MULOP(3), .FUSE_EN(g == 0 ? 1 : 0)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .x_vld          (x_vld && (sel == (g != 0))),
      .x_op           (x_op),
      .x_rs1          (x_rs1),
      .x_rs2          (x_rs2),
      .x_flush        (x_flush && (sel == (g != 0))),
      .x_advance      (x_advance && (sel == (g != 0))),
      .x_stall        (stall_v[g]),
      .x_result       (result_v[g]),
      .x_result_vld   (rvld_v[g]),
      .mul_op         (op_v[g]),
      .mul_op_vld     (op_vld_v[g]),
      .mul_op_rdy     (rdy_v[g]),
      .mul_op_kill    (kill_v[g]),
      .mul_op_a       (a_v[g]),
      .mul_op_b       (b_v[g]),
      .mul_result_h   (rh),
      .mul_result_l   (rl),
      .mul_result_vld (rvld)
    );

    assign rdy_v[g] = !busy;

    // Responder: LAT+1 cycles per op, accumulator held stable while idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy <= 1'b0; rvld <= 1'b0; cnt <= '0; pop <= '0;
        pa <= '0; pb <= '0; rh <= '0; rl <= '0;
      end else begin
        rvld <= 1'b0;
        if (kill_v[g]) begin
          busy <= 1'b0;
        end else if (busy) begin
          if (cnt == 4'd0) begin
            {rh, rl} <= ref_calc(pop, pa, pb);
            rvld     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end else if (op_vld_v[g]) begin
          busy <= 1'b1;
          cnt  <= 4'(LAT);
          pop  <= op_v[g];
          pa   <= a_v[g];
          pb   <= b_v[g];
        end
      end
    end
  end

  assign x_stall      = stall_v[sel];
  assign x_result     = result_v[sel];
  assign x_result_vld = rvld_v[sel];
  assign mul_op_vld   = op_vld_v[sel];
  assign mul_op_kill  = kill_v[sel];
  assign mul_op_rdy   = rdy_v[sel];

  always @(posedge clk) begin
    if (mul_op_vld && mul_op_rdy) n_issue <= n_issue + 1;
    if (mul_op_kill) n_kill <= n_kill + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expv);
    end
  endtask

  // end_mode: 0 advance, 1 flush, 2 flush+advance. exp_issue/exp_stall < 0 skip that check.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int exp_issue,
                        input int exp_stall, input int end_mode);
    int n_stall, n_vld, n_cyc, iss0;
    bit done;
    sb_q.push_back(expv);
    iss0 = n_issue;
    x_op = op; x_rs1 = a; x_rs2 = b; x_vld = 1'b1;
    n_stall = 0; n_vld = 0; n_cyc = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (x_result_vld) begin
        done = 1'b1;
      end else begin
        n_cyc++;
        if (x_stall) n_stall++;
        if (mul_op_vld) n_vld++;
        @(negedge clk);
      end
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      chk({name, "_result"}, x_result, sb_q.pop_front());
      chk({name, "_stall_held"}, n_stall, n_cyc);
      if (exp_stall >= 0) chk({name, "_stall_len"}, n_stall, exp_stall);
      if (exp_issue >= 0) begin
        chk({name, "_vld_cycles"}, n_vld, exp_issue);
        chk({name, "_issues"}, n_issue - iss0, exp_issue);
      end
    end
    x_advance = (end_mode != 1);
    x_flush   = (end_mode != 0);
    @(negedge clk);
    x_vld = 1'b0; x_advance = 1'b0; x_flush = 1'b0;
    #1 chk({name, "_idle_after"}, 32'({x_result_vld, x_stall}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, k0;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 32'(x_stall), 32'd0);
    chk("rst_result_vld", 32'(x_result_vld), 32'd0);
    chk("rst_op_vld", 32'(mul_op_vld), 32'd0);
    chk("rst_kill", 32'(mul_op_kill), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1, -1, 0);
    run_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1, -1, 0);
    run_op("mul_fused", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0, 1, 0);
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, -1, 0);
    run_op("rem_fused", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1, 0);
    run_op("remu_nofuse", OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 1, -1, 0);
    run_op("mul_first", OP_MUL, 32'd3, 32'd5, 32'd15, 1, -1, 0);
    run_op("mulh_after_mul", OP_MULH, 32'd3, 32'd5, 32'd0, 1, -1, 0);
    run_op("mulhu_doneflush", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, -1, 1);
    run_op("mul_after_flush", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 1, 2);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1, 0);
    run_op("mul_su_fused", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 1, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 0);
    run_op("divu_zero", OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, -1, 0);
    run_op("remu_zero", OP_REMU, 32'd1234, 32'd0, 32'd1234, 0, 1, 0);
    run_op("div_10_3", OP_DIV, 32'd10, 32'd3, 32'd3, 1, -1, 0);
    run_op("rem_diff_b", OP_REM, 32'd10, 32'd4, 32'd2, 1, -1, 0);

    // Flush while still in IDLE: nothing may be issued.
    i0 = n_issue;
    x_op = OP_DIV; x_rs1 = 32'd9; x_rs2 = 32'd2; x_vld = 1'b1; x_flush = 1'b1;
    #1;
    chk("idle_flush_op_vld", 32'(mul_op_vld), 32'd0);
    chk("idle_flush_stall", 32'(x_stall), 32'd0);
    @(negedge clk);
    x_vld = 1'b0; x_flush = 1'b0;
    #1;
    chk("idle_flush_issues", n_issue - i0, 32'd0);
    chk("idle_flush_result_vld", 32'(x_result_vld), 32'd0);

    // Flush five cycles into a MULHU.
    i0 = n_issue; k0 = n_kill;
    x_op = OP_MULHU; x_rs1 = 32'h1234_5678; x_rs2 = 32'h9ABC_DEF0; x_vld = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("busy_stall", 32'(x_stall), 32'd1);
    x_flush = 1'b1;
    #1;
    chk("kill_pulse", 32'(mul_op_kill), 32'd1);
    chk("kill_no_vld", 32'(mul_op_vld), 32'd0);
    @(negedge clk);
    x_flush = 1'b0; x_vld = 1'b0;
    #1;
    chk("kill_released", 32'(mul_op_kill), 32'd0);
    chk("kill_count", n_kill - k0, 32'd1);
    chk("flush_issues", n_issue - i0, 32'd1);
    chk("flush_stall", 32'(x_stall), 32'd0);
    chk("flush_result_vld", 32'(x_result_vld), 32'd0);
    run_op("mul_after_kill", OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0,
           expect_of(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0), 1, -1, 0);

    // Reset in BUSY.
    x_op = OP_DIVU; x_rs1 = 32'd50; x_rs2 = 32'd3; x_vld = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    x_vld = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(x_stall), 32'd0);
    chk("midrst_result_vld", 32'(x_result_vld), 32'd0);
    chk("midrst_op_vld", 32'(mul_op_vld), 32'd0);
    chk("midrst_kill", 32'(mul_op_kill), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 1, -1, 0);

    for (int n = 0; n < 8; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = (n == 3) ? 32'd0 : $urandom();
      run_op("rand", rop, ra, rb, expect_of(rop, ra, rb), -1, -1, 0);
    end

    // Non-fusing instance: the MUL is reissued and results are unchanged.
    sel = 1'b1;
    @(negedge clk);
    run_op("nf_mulh", OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1, -1, 0);
    run_op("nf_mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1, -1, 0);
    run_op("nf_div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, -1, 0);
    run_op("nf_rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
